// File: rtl/fft_out_reorder.sv
// Ping-pong reorder buffer for the 64-point FFT output. It takes bit-reversed bin
// pairs, two per cycle, and emits the bins in natural order, one per cycle, over valid/ready.
module fft_out_reorder #(
  parameter int BW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_start,
  input  logic          in_valid,
  input  logic [BW-1:0] inReal0,
  input  logic [BW-1:0] inImag0,
  input  logic [BW-1:0] inReal1,
  input  logic [BW-1:0] inImag1,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [BW-1:0] outReal,
  output logic [BW-1:0] outImag,
  output logic [5:0]    out_index,
  output logic          out_last,
  output logic          overflow,
  output logic          frame_err
);

  typedef enum logic [1:0] {B_EMPTY, B_FULL, B_READING} bstat_e;
  typedef enum logic [1:0] {W_IDLE, W_FILL, W_DROP}     wstate_e;
  typedef enum logic       {R_IDLE, R_RUN}              rstate_e;

  function automatic logic [4:0] rev5(input logic [4:0] k);
    return {k[0], k[1], k[2], k[3], k[4]};
  endfunction

  // {buffer, addr}-indexed banks: U holds bins 0..31, L holds bins 32..63
  logic [2*BW-1:0] mem_u [64];
  logic [2*BW-1:0] mem_l [64];

  wstate_e      wst_q, wst_d;
  rstate_e      rst_q, rst_d;
  bstat_e       bst_q [2];
  bstat_e       bst_d [2];
  logic [4:0]   k_q, k_d;
  logic         wbuf_q, wbuf_d, rbuf_q, rbuf_d;
  logic [5:0]   n_q, n_d;
  logic         done_q, done_d;
  logic         ov_q, ov_d, last_q, last_d, ovf_q, ovf_d, ferr_q, ferr_d;
  logic [5:0]   idx_q, idx_d;
  logic [2*BW-1:0] dat_q;

  logic       we, iss, iss_buf, adv, acc_last, release_c, wfree, start;
  logic [4:0] wk;
  logic [5:0] iss_bin;

  always_comb begin
    wst_d = wst_q; rst_d = rst_q; bst_d = bst_q; k_d = k_q;
    wbuf_d = wbuf_q; rbuf_d = rbuf_q; n_d = n_q; done_d = done_q;
    ovf_d = ovf_q; ferr_d = ferr_q;
    we = 1'b0; wk = '0; iss = 1'b0; iss_buf = rbuf_q; iss_bin = '0;
    release_c = 1'b0;
    adv      = !ov_q || out_ready;
    acc_last = ov_q && out_ready && last_q;

    // Read side runs first so the write side can see this cycle's release.
    case (rst_q)
      R_IDLE: if (bst_q[rbuf_q] == B_FULL) begin
        iss = 1'b1; bst_d[rbuf_q] = B_READING;
        rst_d = R_RUN; n_d = 6'd1; done_d = 1'b0;
      end
      R_RUN: if (acc_last) begin
        release_c = 1'b1;
        bst_d[rbuf_q] = B_EMPTY;
        rbuf_d = ~rbuf_q;
        // A pending full buffer is issued in the same cycle so out_valid has no gap.
        if (bst_q[~rbuf_q] == B_FULL) begin
          iss = 1'b1; iss_buf = ~rbuf_q; bst_d[~rbuf_q] = B_READING;
          n_d = 6'd1; done_d = 1'b0;
        end else begin
          rst_d = R_IDLE;
        end
      end else if (!done_q && adv) begin
        iss = 1'b1; iss_bin = n_q; n_d = n_q + 6'd1;
        if (n_q == 6'd63) done_d = 1'b1;
      end
      default: rst_d = R_IDLE;
    endcase

    start = in_start && in_valid;
    wfree = (bst_q[wbuf_q] == B_EMPTY) || (release_c && (rbuf_q == wbuf_q));
    if (start && wst_q != W_FILL) begin
      k_d = 5'd1;
      if (wfree) begin
        we = 1'b1; wst_d = W_FILL;
      end else begin
        ovf_d = 1'b1; wst_d = W_DROP;
      end
    end else if (start) begin
      // Truncated frame: restart in the same buffer with this pair as pair 0.
      ferr_d = 1'b1; we = 1'b1; k_d = 5'd1;
    end else if (in_valid) begin
      case (wst_q)
        W_FILL: begin
          we = 1'b1; wk = k_q; k_d = k_q + 5'd1;
          if (k_q == 5'd31) begin
            wst_d = W_IDLE; bst_d[wbuf_q] = B_FULL; wbuf_d = ~wbuf_q;
          end
        end
        W_DROP: begin
          k_d = k_q + 5'd1;
          if (k_q == 5'd31) wst_d = W_IDLE;
        end
        default: ferr_d = 1'b1;
      endcase
    end

    ov_d = ov_q; idx_d = idx_q; last_d = last_q;
    if (adv) begin
      ov_d   = iss;
      last_d = iss && (iss_bin == 6'd63);
      if (iss) idx_d = iss_bin;
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      mem_u[{wbuf_q, rev5(wk)}] <= {inReal0, inImag0};
      mem_l[{wbuf_q, rev5(wk)}] <= {inReal1, inImag1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wst_q <= W_IDLE; rst_q <= R_IDLE;
      bst_q[0] <= B_EMPTY; bst_q[1] <= B_EMPTY;
      k_q <= '0; wbuf_q <= 1'b0; rbuf_q <= 1'b0; n_q <= '0; done_q <= 1'b0;
      ov_q <= 1'b0; last_q <= 1'b0; idx_q <= '0; dat_q <= '0;
      ovf_q <= 1'b0; ferr_q <= 1'b0;
    end else begin
      wst_q <= wst_d; rst_q <= rst_d; bst_q <= bst_d;
      k_q <= k_d; wbuf_q <= wbuf_d; rbuf_q <= rbuf_d; n_q <= n_d; done_q <= done_d;
      ov_q <= ov_d; last_q <= last_d; idx_q <= idx_d;
      ovf_q <= ovf_d; ferr_q <= ferr_d;
      if (iss) dat_q <= iss_bin[5] ? mem_l[{iss_buf, iss_bin[4:0]}]
                                   : mem_u[{iss_buf, iss_bin[4:0]}];
    end
  end

  assign out_valid = ov_q;
  assign out_last  = last_q;
  assign out_index = idx_q;
  assign outReal   = dat_q[2*BW-1:BW];
  assign outImag   = dat_q[BW-1:0];
  assign overflow  = ovf_q;
  assign frame_err = ferr_q;

endmodule

// File: tb/tb_fft_out_reorder.sv
// Directed bench for fft_out_reorder: frames carry base+bin in real and its
// negation in imag, so every accepted output can be checked against its index.
module tb_fft_out_reorder;
  localparam int BW = 16;

  logic clk = 1'b0, rst = 1'b1, in_start = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [BW-1:0] inReal0 = '0, inImag0 = '0, inReal1 = '0, inImag1 = '0;
  logic out_valid, out_last, overflow, frame_err;
  logic [BW-1:0] outReal, outImag;
  logic [5:0] out_index;

  fft_out_reorder #(.BW(BW)) dut (
    .clk(clk), .rst(rst), .in_start(in_start), .in_valid(in_valid),
    .inReal0(inReal0), .inImag0(inImag0), .inReal1(inReal1), .inImag1(inImag1),
    .out_valid(out_valid), .out_ready(out_ready), .outReal(outReal), .outImag(outImag),
    .out_index(out_index), .out_last(out_last), .overflow(overflow), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] rev5(input logic [4:0] k);
    return {k[0], k[1], k[2], k[3], k[4]};
  endfunction

  // Output monitor: captures accepted bins and checks stalled outputs hold.
  logic [38:0] q[$];
  int first_vld = -1, last_cyc = -1, last_cnt = 0;
  logic stall = 1'b0;
  logic [39:0] snap;
  always @(negedge clk) begin
    if (rst) stall = 1'b0;
    else begin
      if (stall) chk("hold", {24'd0, out_valid, out_index, out_last, outReal, outImag}, {24'd0, snap});
      if (out_valid && first_vld < 0) first_vld = cyc;
      if (out_valid && out_ready) begin
        q.push_back({out_index, out_last, outReal, outImag});
        if (out_last) begin last_cnt++; last_cyc = cyc; end
      end
      stall = out_valid && !out_ready;
      snap  = {out_valid, out_index, out_last, outReal, outImag};
    end
  end

  // Ready driver: constant 1, or the 1,0,0,1 backpressure pattern.
  logic bp_mode = 1'b0;
  logic [3:0] pat = 4'b1001;
  int bp_i = 0;
  initial forever begin
    @(posedge clk); #1;
    out_ready = bp_mode ? pat[bp_i] : 1'b1;
    bp_i = (bp_i + 1) % 4;
  end

  int lp;
  task automatic clear_mon();
    q.delete(); first_vld = -1; last_cyc = -1; last_cnt = 0;
  endtask

  task automatic send_frame(input int base, input int np);
    for (int k = 0; k < np; k++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; in_start = (k == 0);
      inReal0 = 16'(base + int'(rev5(5'(k))));
      inReal1 = 16'(base + 32 + int'(rev5(5'(k))));
      inImag0 = -inReal0;
      inImag1 = -inReal1;
      lp = cyc;
    end
  endtask

  task automatic idle();
    @(posedge clk); #1; in_valid = 1'b0; in_start = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1; rst = 1'b1; in_valid = 1'b0; in_start = 1'b0;
    @(posedge clk); #1; rst = 1'b0; clear_mon();
  endtask

  task automatic wait_bins(input int n, input int budget);
    int b = 0;
    while (q.size() < n && b < budget) begin @(posedge clk); b++; end
    repeat (10) @(posedge clk);
    chk("count", 64'(q.size()), 64'(n));
  endtask

  task automatic check_frame(input int off, input int base);
    logic [15:0] r;
    logic [5:0]  ix;
    for (int i = 0; i < 64; i++) begin
      r = 16'(base + i); ix = 6'(i);
      if (off + i < q.size()) chk("bin", {25'd0, q[off+i]}, {25'd0, ix, (i == 63), r, -r});
      else chk("bin_missing", 64'(q.size()), 64'(off + i + 1));
    end
  endtask

  task automatic chk_zero_outs(input string tag);
    chk({tag, "_valid"}, {63'd0, out_valid}, 64'd0);
    chk({tag, "_last"},  {63'd0, out_last},  64'd0);
    chk({tag, "_idx"},   {58'd0, out_index}, 64'd0);
    chk({tag, "_data"},  {32'd0, outReal, outImag}, 64'd0);
    chk({tag, "_ovf"},   {63'd0, overflow},  64'd0);
    chk({tag, "_ferr"},  {63'd0, frame_err}, 64'd0);
  endtask

  initial begin
    int t, b;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero_outs("reset");
    @(posedge clk); #1; rst = 1'b0;

    // Single frame with latency checks
    clear_mon();
    send_frame(0, 32); t = lp; idle();
    wait_bins(64, 300);
    chk("lat_first", 64'(first_vld), 64'(t + 2));
    chk("lat_last", 64'(last_cyc), 64'(t + 65));
    chk("last_cnt", 64'(last_cnt), 64'd1);
    check_frame(0, 0);

    // Backpressure 1,0,0,1
    bp_mode = 1'b1; clear_mon();
    send_frame(10, 32); idle();
    wait_bins(64, 600);
    check_frame(0, 10);
    chk("bp_last_cnt", 64'(last_cnt), 64'd1);
    bp_mode = 1'b0;

    // Four frames, in_start every 64 cycles
    clear_mon();
    for (int f = 0; f < 4; f++) begin
      send_frame(100 * (f + 1), 32); idle();
      repeat (31) @(posedge clk);
    end
    wait_bins(256, 600);
    for (int f = 0; f < 4; f++) check_frame(64 * f, 100 * (f + 1));
    chk("r64_ovf", {63'd0, overflow}, 64'd0);
    chk("r64_ferr", {63'd0, frame_err}, 64'd0);

    // Four frames back to back: frame 2 dropped
    do_reset();
    for (int f = 0; f < 4; f++) send_frame(500 + 100 * f, 32);
    idle();
    wait_bins(192, 800);
    check_frame(0, 500);
    check_frame(64, 600);
    check_frame(128, 800);
    chk("r32_ovf", {63'd0, overflow}, 64'd1);
    chk("r32_ferr", {63'd0, frame_err}, 64'd0);

    // Truncated frame followed by a full one
    do_reset();
    send_frame(900, 10);
    send_frame(1000, 32); idle();
    wait_bins(64, 300);
    check_frame(0, 1000);
    chk("trunc_ferr", {63'd0, frame_err}, 64'd1);
    chk("trunc_ovf", {63'd0, overflow}, 64'd0);

    // Stray in_valid without in_start
    do_reset();
    repeat (5) begin @(posedge clk); #1; in_valid = 1'b1; in_start = 1'b0; end
    idle();
    repeat (80) @(posedge clk);
    chk("stray_ferr", {63'd0, frame_err}, 64'd1);
    chk("stray_outs", 64'(q.size()), 64'd0);

    // Reset while presenting index 20
    do_reset();
    send_frame(1100, 32); idle();
    b = 0;
    do begin @(negedge clk); b++; end while (!(out_valid && out_index == 6'd20) && b < 300);
    chk("reach_idx20", {57'd0, out_valid, out_index}, {57'd0, 1'b1, 6'd20});
    rst = 1'b1;
    @(negedge clk);
    chk_zero_outs("midrst");
    @(posedge clk); #1; rst = 1'b0;
    clear_mon();
    send_frame(1200, 32); idle();
    wait_bins(64, 300);
    check_frame(0, 1200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
